alu_share_arbiter: RTL and testbench

Two-requester round-robin arbiter that time-shares a single `ALU` datapath instance. Each requester presents operands and an ALU control code over a valid/ready handshake. The arbiter grants one request per cycle, registers the ALU result, and returns it on one response channel tagged with the requester ID. It sits between the execute-stage issue logic and the shared ALU, for example between a main pipe and an address-generation or test port.

---
 rtl/alu_pkg.sv | 15 +
 rtl/ALU.sv | 39 +++
 rtl/rr_pick2.sv | 13 +
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 tb/tb_alu_share_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and ALU control code constants for the shared-ALU arbiter slice.
package alu_pkg;

  typedef logic [3:0] alu_ctrl_t;
  typedef logic       req_id_t;

  localparam alu_ctrl_t ALU_AND = 4'b0000;
  localparam alu_ctrl_t ALU_OR  = 4'b0001;
  localparam alu_ctrl_t ALU_ADD = 4'b0010;
  localparam alu_ctrl_t ALU_SLL = 4'b0011;
  localparam alu_ctrl_t ALU_SUB = 4'b0110;
  localparam alu_ctrl_t ALU_SRL = 4'b0111;
  localparam alu_ctrl_t ALU_SRA = 4'b1000;

endpackage

// File: rtl/ALU.sv
// Combinational ALU: logic, add/sub and shifts by the full b operand.
module ALU
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  alu_ctrl_t    ctrl,
  output logic [W-1:0] result,
  output logic         zero
);

  localparam int unsigned SW = $clog2(W);

  logic         w_shift_oob;
  logic [SW-1:0] w_shamt;

  // Negative b reads as a large unsigned value, so it lands out of range too.
  assign w_shift_oob = (b >= W'(W));
  assign w_shamt     = b[SW-1:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLL: result = w_shift_oob ? '0 : (a << w_shamt);
      ALU_SRL: result = w_shift_oob ? '0 : (a >> w_shamt);
      ALU_SRA: result = w_shift_oob ? {W{a[W-1]}} : W'($signed(a) >>> w_shamt);
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker; last_grant loses a tie.
module rr_pick2
  import alu_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  assign grant[0] = valid[0] && (!valid[1] || (last_grant == 1'b1));
  assign grant[1] = valid[1] && (!valid[0] || (last_grant == 1'b0));

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end to one shared ALU with a single response slot.
// Optional per-requester grant counters are enabled by defining ALU_ARB_STATS_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  alu_ctrl_t    req_ctrl0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  alu_ctrl_t    req_ctrl1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output req_id_t      rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_zero
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  logic         r_rsp_valid;
  req_id_t      r_rsp_id;
  logic [W-1:0] r_rsp_result;
  logic         r_rsp_zero;
  req_id_t      r_last_grant;

  logic [1:0]   w_grant;
  logic         w_slot_free;
  logic         w_xfer;
  req_id_t      w_sel;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  alu_ctrl_t    w_ctrl;
  logic [W-1:0] w_result;
  logic         w_zero;

  rr_pick2 u_pick (
    .valid      (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign req_ready   = w_grant & {2{w_slot_free}};
  assign w_xfer      = |req_ready;
  assign w_sel       = req_ready[1];

  assign w_a    = w_sel ? req_a1    : req_a0;
  assign w_b    = w_sel ? req_b1    : req_b0;
  assign w_ctrl = w_sel ? req_ctrl1 : req_ctrl0;

  ALU #(
    .W (W)
  ) u_alu (
    .a      (w_a),
    .b      (w_b),
    .ctrl   (w_ctrl),
    .result (w_result),
    .zero   (w_zero)
  );

  // Drain without a new transfer only clears valid; payload stays stale.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_sel;
      r_rsp_result <= w_result;
      r_rsp_zero   <= w_zero;
      r_last_grant <= w_sel;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req_ready[0]) r_cnt0 <= r_cnt0 + 16'd1;
      if (req_ready[1]) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter; expected responses queue on predicted transfers.
module tb_alu_share_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]  req_ctrl0, req_ctrl1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  logic m_last;

  alu_share_arbiter #(
    .W (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_ctrl0  (req_ctrl0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .req_ctrl1  (req_ctrl1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
    logic big;
    big = ($signed(b) < 0) || (b > 32'd31);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0011: return big ? 32'd0 : a << b;
      4'b0111: return big ? 32'd0 : a >> b;
      4'b1000: return big ? {32{a[31]}} : 32'($signed(a) >>> b);
      default: return 32'd0;
    endcase
  endfunction

  // Called at a negedge with inputs already driven; advances one clock.
  task automatic step();
    exp_t        e;
    logic [1:0]  g;
    logic        free;
    logic [31:0] r;
    #1;
    check_eq("rsp_valid", rsp_valid, sb.size() != 0);
    free = (sb.size() == 0) || rsp_ready;
    if (sb.size() != 0) begin
      e = sb[0];
      check_eq("rsp_id", rsp_id, e.id);
      check_eq("rsp_result", rsp_result, e.res);
      check_eq("rsp_zero", rsp_zero, e.zero);
      if (rsp_ready) e = sb.pop_front();
    end
    g[0] = req_valid[0] && (!req_valid[1] || m_last);
    g[1] = req_valid[1] && (!req_valid[0] || !m_last);
    if (!free) g = 2'b00;
    check_eq("req_ready", req_ready, g);
    if (g != 2'b00) begin
      r = g[1] ? alu_model(req_a1, req_b1, req_ctrl1) : alu_model(req_a0, req_b0, req_ctrl0);
      sb.push_back('{id: g[1], res: r, zero: (r == 32'd0)});
      m_last = g[1];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set0(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_a0 = a; req_b0 = b; req_ctrl0 = c;
  endtask

  task automatic set1(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    req_a1 = a; req_b1 = b; req_ctrl1 = c;
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    set0(0, 0, 0);
    set1(0, 0, 0);
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset_valid", rsp_valid, 0);
    check_eq("reset_id", rsp_id, 0);
    check_eq("reset_result", rsp_result, 0);
    check_eq("reset_zero", rsp_zero, 0);
    reset = 1'b0;
    @(negedge clk);

    // Single request: 5 + 3
    req_valid = 2'b01;
    set0(32'd5, 32'd3, 4'b0010);
    step();
    req_valid = 2'b00;
    step();
    step();

    // Contention: SUB 7-7 vs SRA 0x80000000>>4, alternating grants
    set0(32'd7, 32'd7, 4'b0110);
    set1(32'h8000_0000, 32'd4, 4'b1000);
    req_valid = 2'b11;
    repeat (4) step();
    req_valid = 2'b00;
    step();

    // Backpressure with both valid
    req_valid = 2'b11;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    rsp_ready = 1'b1;
    repeat (2) step();
    req_valid = 2'b00;
    step();

    // Shifts and an illegal code
    req_valid = 2'b01;
    set0(32'd1, 32'd32, 4'b0011);
    step();
    set0(32'hF000_0000, 32'd4, 4'b0111);
    step();
    set0(32'h1234_5678, 32'd9, 4'b0101);
    step();
    set0(32'h8000_0001, 32'd40, 4'b1000);
    step();
    set0(32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0000);
    step();
    set0(32'h0000_00F0, 32'h0000_000F, 4'b0001);
    step();
    req_valid = 2'b00;
    step();

    // Randomised mix with occasional backpressure
    for (int i = 0; i < 200; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      set0($urandom, 32'($urandom_range(0, 40)), 4'($urandom_range(0, 8)));
      set1($urandom, 32'($urandom_range(0, 40)), 4'($urandom_range(0, 8)));
      step();
      // Hold operands of a stalled request stable for the next cycle.
      if (sb.size() != 0 && !rsp_ready) begin
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        step();
      end
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    step();

    // Reset while a response is held
    req_valid = 2'b01;
    set0(32'd10, 32'd20, 4'b0010);
    rsp_ready = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check_eq("midreset_valid", rsp_valid, 0);
    check_eq("midreset_result", rsp_result, 0);
    sb.delete();
    m_last = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    set1(32'd1, 32'd1, 4'b0010);
    step();
    req_valid = 2'b00;
    step();

`ifdef ALU_ARB_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    m_last = 1'b1;
    check_eq("cnt0_reset", grant_cnt0, 0);
    check_eq("cnt1_reset", grant_cnt1, 0);
    req_valid = 2'b10;
    set1(32'd3, 32'd4, 4'b0010);
    for (int i = 0; i < 70000; i++) step();
    req_valid = 2'b00;
    step();
    check_eq("grant_cnt1", grant_cnt1, 16'd4464);
    check_eq("grant_cnt0", grant_cnt0, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
